resp_route_ic: RTL and testbench

RESP_ROUTE_IC -- requirements
Module: resp_route_ic

---
 rtl/icache_interco_pkg.sv | 17 +
 rtl/resp_id_fifo_ic.sv | 66 ++++++
 rtl/resp_route_ic.sv | 92 +++++++++
 tb/tb_resp_route_ic.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/icache_interco_pkg.sv
// ============================================================================
// icache_interco_pkg : shared defaults and derived widths for the response router
// Rev 1.0
// ============================================================================
`default_nettype none

package icache_interco_pkg;

  localparam int N_CH_DEF       = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CH_ID_W        = $clog2(N_CH_DEF);
  localparam int FIFO_PTR_W     = $clog2(FIFO_DEPTH_DEF);
  localparam int FIFO_CNT_W     = FIFO_PTR_W + 1;

endpackage

`default_nettype wire

// File: rtl/resp_id_fifo_ic.sv
// ============================================================================
// resp_id_fifo_ic : in-order FIFO of granted channel ids awaiting a response
// Rev 1.0
// ============================================================================
`default_nettype none

module resp_id_fifo_ic
  import icache_interco_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = CH_ID_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Pop on empty and push on full are dropped so occupancy can never wrap.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/resp_route_ic.sv
// ============================================================================
// resp_route_ic : round-robin N:1 request arbiter with in-order response routing
// Rev 1.0
// ============================================================================
`default_nettype none

module resp_route_ic
  import icache_interco_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CH-1:0]                data_req_i,
  input  logic [N_CH-1:0][ADDR_WIDTH-1:0] data_add_i,
  output logic [N_CH-1:0]                data_gnt_o,
  output logic [N_CH-1:0]                data_r_valid_o,
  output logic [DATA_WIDTH-1:0]          data_r_rdata_o,
  output logic                           data_req_o,
  output logic [ADDR_WIDTH-1:0]          data_add_o,
  input  logic                           data_gnt_i,
  input  logic                           data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]          data_r_rdata_i
);

  localparam int ID_W = $clog2(N_CH);

  logic [ID_W-1:0] rr_q, rr_d;
  logic [ID_W-1:0] winner, idx, head;
  logic            found;
  logic            fifo_full, fifo_empty;
  logic            handshake, pop;

  // Search starts at rr_q; the id width wraps the index modulo N_CH.
  always_comb begin
    winner = rr_q;
    idx    = rr_q;
    found  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = rr_q + ID_W'(i);
      if (!found && data_req_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    data_req_o     = (|data_req_i) & ~fifo_full;
    handshake      = data_req_o & data_gnt_i;
    pop            = data_r_valid_i & ~fifo_empty;
    rr_d           = handshake ? (winner + ID_W'(1)) : rr_q;
    data_add_o     = data_add_i[winner];
    data_gnt_o     = '0;
    data_gnt_o[winner] = handshake;
    data_r_valid_o = '0;
    data_r_valid_o[head] = pop;
    data_r_rdata_o = data_r_rdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  resp_id_fifo_ic #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (handshake),
    .pop_i   (pop),
    .wdata_i (winner),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  a_no_resp_when_empty: assert property (
    @(posedge clk) disable iff (!rst_n) !(data_r_valid_i && fifo_empty)
  ) else $warning("resp_route_ic: response received with no outstanding request");

endmodule

`default_nettype wire

// File: tb/tb_resp_route_ic.sv
// ============================================================================
// tb_resp_route_ic : randomized + directed bench with a queue-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_resp_route_ic;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int D  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req_i;
  logic [N-1:0][AW-1:0] add_i;
  logic                 gnt_i, rv_i;
  logic [DW-1:0]        rd_i;
  logic [N-1:0]         data_gnt_o, data_r_valid_o;
  logic [DW-1:0]        data_r_rdata_o;
  logic                 data_req_o;
  logic [AW-1:0]        data_add_o;

  int checks = 0;
  int failures = 0;
  int mq[$];
  int rr = 0;

  always #5 clk = ~clk;

  resp_route_ic #(
    .N_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_req_i     (req_i),
    .data_add_i     (add_i),
    .data_gnt_o     (data_gnt_o),
    .data_r_valid_o (data_r_valid_o),
    .data_r_rdata_o (data_r_rdata_o),
    .data_req_o     (data_req_o),
    .data_add_o     (data_add_o),
    .data_gnt_i     (gnt_i),
    .data_r_valid_i (rv_i),
    .data_r_rdata_i (rd_i)
  );

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference model: a queue of outstanding channel ids and a plain round-robin index.
  always @(negedge clk) begin
    int w;
    bit er, hs;
    logic [N-1:0] eg, ev;
    if (!rst_n) begin
      mq.delete();
      rr = 0;
    end
    er = (req_i != '0) && (mq.size() < D);
    w  = rr;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[(rr + i) % N]) w = (rr + i) % N;
    hs = er && gnt_i;
    eg = '0;
    if (hs) eg[w] = 1'b1;
    ev = '0;
    if (rv_i && mq.size() > 0) ev[mq[0]] = 1'b1;
    chk("m_req_o", data_req_o, er);
    chk("m_gnt_o", data_gnt_o, eg);
    chk("m_rvalid_o", data_r_valid_o, ev);
    chk("m_rdata_o", data_r_rdata_o, rd_i);
    if (er) chk("m_add_o", data_add_o, add_i[w]);
    if (rst_n) begin
      if (rv_i && mq.size() > 0) void'(mq.pop_front());
      if (hs) begin
        mq.push_back(w);
        rr = (w + 1) % N;
      end
    end
  end

  task automatic drive(input logic [N-1:0] r, input logic g, input logic v);
    req_i = r;
    gnt_i = g;
    rv_i  = v;
    for (int c = 0; c < N; c++) add_i[c] = $urandom;
    rd_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input logic [N-1:0] r, input logic g, input logic v,
                     input string n, input logic [N-1:0] eg, input logic [N-1:0] ev,
                     input logic ereq);
    drive(r, g, v);
    settle();
    chk({n, "_gnt"}, data_gnt_o, eg);
    chk({n, "_rvalid"}, data_r_valid_o, ev);
    chk({n, "_req"}, data_req_o, ereq);
    chk({n, "_rdata"}, data_r_rdata_o, rd_i);
    next();
  endtask

  initial begin
    drive('0, 1'b0, 1'b0);
    rst_n = 1'b0;
    settle();
    chk("rst_req", data_req_o, 1'b0);
    chk("rst_gnt", data_gnt_o, '0);
    chk("rst_rvalid", data_r_valid_o, '0);
    next();
    next();
    rst_n = 1'b1;

    // Rotation over all channels, then fill, one response frees a slot.
    lit(4'b1111, 1'b1, 1'b0, "rot0", 4'b0001, 4'b0000, 1'b1);
    lit(4'b1111, 1'b1, 1'b0, "rot1", 4'b0010, 4'b0000, 1'b1);
    lit(4'b1111, 1'b1, 1'b0, "rot2", 4'b0100, 4'b0000, 1'b1);
    lit(4'b1111, 1'b1, 1'b0, "rot3", 4'b1000, 4'b0000, 1'b1);
    lit(4'b1111, 1'b1, 1'b0, "full", 4'b0000, 4'b0000, 1'b0);
    lit(4'b1111, 1'b1, 1'b1, "fullpop", 4'b0000, 4'b0001, 1'b0);
    lit(4'b1111, 1'b1, 1'b0, "refill", 4'b0001, 4'b0000, 1'b1);
    lit(4'b0000, 1'b0, 1'b1, "drain1", 4'b0000, 4'b0010, 1'b0);
    lit(4'b0000, 1'b0, 1'b1, "drain2", 4'b0000, 4'b0100, 1'b0);
    lit(4'b0000, 1'b0, 1'b1, "drain3", 4'b0000, 4'b1000, 1'b0);
    lit(4'b0000, 1'b0, 1'b1, "drain0", 4'b0000, 4'b0001, 1'b0);

    // Pointer at 1 then 3: single requester on channel 2 wins both times.
    lit(4'b0100, 1'b1, 1'b0, "ch2a", 4'b0100, 4'b0000, 1'b1);
    lit(4'b0100, 1'b1, 1'b0, "ch2b", 4'b0100, 4'b0000, 1'b1);
    lit(4'b0000, 1'b0, 1'b1, "rsp2a", 4'b0000, 4'b0100, 1'b0);
    lit(4'b0000, 1'b0, 1'b1, "rsp2b", 4'b0000, 4'b0100, 1'b0);

    // Two outstanding, then handshake and response together.
    lit(4'b0010, 1'b1, 1'b0, "os1", 4'b0010, 4'b0000, 1'b1);
    lit(4'b1000, 1'b1, 1'b0, "os3", 4'b1000, 4'b0000, 1'b1);
    lit(4'b0001, 1'b1, 1'b1, "pushpop", 4'b0001, 4'b0010, 1'b1);
    lit(4'b0000, 1'b0, 1'b1, "pp_r3", 4'b0000, 4'b1000, 1'b0);
    lit(4'b0000, 1'b0, 1'b1, "pp_r0", 4'b0000, 4'b0001, 1'b0);

    // Response with nothing outstanding must be dropped.
    lit(4'b0000, 1'b0, 1'b1, "viol", 4'b0000, 4'b0000, 1'b0);
    lit(4'b0001, 1'b1, 1'b0, "aft_v", 4'b0001, 4'b0000, 1'b1);
    lit(4'b0000, 1'b0, 1'b1, "aft_vr", 4'b0000, 4'b0001, 1'b0);

    // Reset with three outstanding flushes routing state.
    lit(4'b1111, 1'b1, 1'b0, "pre1", 4'b0010, 4'b0000, 1'b1);
    lit(4'b1111, 1'b1, 1'b0, "pre2", 4'b0100, 4'b0000, 1'b1);
    lit(4'b1111, 1'b1, 1'b0, "pre3", 4'b1000, 4'b0000, 1'b1);
    drive('0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    settle();
    chk("mid_rst_req", data_req_o, 1'b0);
    chk("mid_rst_gnt", data_gnt_o, '0);
    chk("mid_rst_rvalid", data_r_valid_o, '0);
    next();
    next();
    rst_n = 1'b1;
    lit(4'b0000, 1'b0, 1'b1, "post_rst_v", 4'b0000, 4'b0000, 1'b0);
    lit(4'b1111, 1'b1, 1'b0, "post_rst_g", 4'b0001, 4'b0000, 1'b1);
    lit(4'b0000, 1'b0, 1'b1, "post_rst_r", 4'b0000, 4'b0001, 1'b0);

    // Random traffic; responses only while something is outstanding.
    for (int k = 0; k < 1500; k++) begin
      drive(N'($urandom), ($urandom % 10) < 7, (mq.size() > 0) && ($urandom % 2 == 1));
      next();
    end

    drive('0, 1'b0, 1'b0);
    next();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
